// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RV32I field bundle -> packed word encoder.
// Ports: clk/resetn/clear; in_* fields (valid/ready); out_* word, addr, err (valid/ready); err_sticky; word_count.
module instr_encoder #(
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [3:0] OP_ALU   = 4'd0;
  localparam logic [3:0] OP_ALUI  = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_LUI   = 4'd4;
  localparam logic [3:0] OP_AUIPC = 4'd5;
  localparam logic [3:0] OP_JAL   = 4'd6;
  localparam logic [3:0] OP_JALR  = 4'd7;
  localparam logic [3:0] OP_SYS   = 4'd8;
  localparam logic [3:0] OP_BR    = 4'd9;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } fld_t;

  fld_t              s1_q, s1_d;
  logic              s1_full_q, s1_full_d;
  logic              val_q, val_d;
  logic [31:0]       ins_q, ins_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              stk_q, stk_d;

  logic              handoff, s1_move, accept;
  logic [31:0]       enc;
  logic              enc_err;
  logic [31:0]       imm;
  logic signed [31:0] imm_s;
  logic              i_bad;

  assign handoff  = val_q && out_ready;
  assign s1_move  = s1_full_q && (!val_q || out_ready);
  assign in_ready = resetn && (!s1_full_q || s1_move);
  assign accept   = in_valid && in_ready && !clear;

  assign imm   = s1_q.imm;
  assign imm_s = s1_q.imm;
  assign i_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);

  always_comb begin
    enc     = '0;
    enc_err = 1'b0;
    case (s1_q.op)
      OP_ALU: enc = {s1_q.f7, s1_q.rs2, s1_q.rs1,
                     s1_q.f3, s1_q.rd, 7'b0110011};
      OP_ALUI: begin
        // Shift-immediates carry funct7 above a 5-bit shamt.
        if (s1_q.f3 == 3'b001 || s1_q.f3 == 3'b101) begin
          enc = {s1_q.f7, imm[4:0], s1_q.rs1,
                 s1_q.f3, s1_q.rd, 7'b0010011};
          enc_err = imm > 32'd31;
        end else begin
          enc = {imm[11:0], s1_q.rs1,
                 s1_q.f3, s1_q.rd, 7'b0010011};
          enc_err = i_bad;
        end
      end
      OP_LOAD: begin
        enc = {imm[11:0], s1_q.rs1,
               s1_q.f3, s1_q.rd, 7'b0000011};
        enc_err = i_bad;
      end
      OP_JALR: begin
        enc = {imm[11:0], s1_q.rs1,
               s1_q.f3, s1_q.rd, 7'b1100111};
        enc_err = i_bad;
      end
      OP_SYS: begin
        enc = {imm[11:0], s1_q.rs1,
               s1_q.f3, s1_q.rd, 7'b1110011};
        enc_err = i_bad;
      end
      OP_STORE: begin
        enc = {imm[11:5], s1_q.rs2, s1_q.rs1,
               s1_q.f3, imm[4:0], 7'b0100011};
        enc_err = i_bad;
      end
      OP_LUI: begin
        enc = {imm[31:12], s1_q.rd, 7'b0110111};
        enc_err = |imm[11:0];
      end
      OP_AUIPC: begin
        enc = {imm[31:12], s1_q.rd, 7'b0010111};
        enc_err = |imm[11:0];
      end
      OP_JAL: begin
        enc = {imm[20], imm[10:1], imm[11],
               imm[19:12], s1_q.rd, 7'b1101111};
        enc_err = (imm_s < -32'sd1048576) ||
                  (imm_s > 32'sd1048574) || imm[0];
      end
      OP_BR: begin
        enc = {imm[12], imm[10:5], s1_q.rs2, s1_q.rs1,
               s1_q.f3, imm[4:1], imm[11], 7'b1100011};
        enc_err = (imm_s < -32'sd4096) ||
                  (imm_s > 32'sd4094) || imm[0];
      end
      default: enc_err = 1'b1;
    endcase
  end

  always_comb begin
    s1_d      = s1_q;
    s1_full_d = s1_full_q;
    val_d     = val_q;
    ins_d     = ins_q;
    err_d     = err_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    stk_d     = stk_q;
    if (clear) begin
      s1_full_d = 1'b0;
      val_d     = 1'b0;
      ins_d     = '0;
      err_d     = 1'b0;
      addr_d    = BASE_ADDR;
      cnt_d     = '0;
      stk_d     = 1'b0;
    end else begin
      if (handoff) begin
        val_d  = 1'b0;
        // Address wraps to zero, not to BASE_ADDR.
        addr_d = addr_q + ADDR_W'(1);
        if (cnt_q != '1) cnt_d = cnt_q + (ADDR_W+1)'(1);
        if (err_q) stk_d = 1'b1;
      end
      if (s1_move) begin
        val_d     = 1'b1;
        ins_d     = enc;
        err_d     = enc_err;
        s1_full_d = 1'b0;
      end
      if (accept) begin
        s1_d      = '{op: in_op, rd: in_rd, rs1: in_rs1,
                      rs2: in_rs2, f3: in_funct3,
                      f7: in_funct7, imm: in_imm};
        s1_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q      <= '0;
      s1_full_q <= 1'b0;
      val_q     <= 1'b0;
      ins_q     <= '0;
      err_q     <= 1'b0;
      addr_q    <= BASE_ADDR;
      cnt_q     <= '0;
      stk_q     <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s1_full_q <= s1_full_d;
      val_q     <= val_d;
      ins_q     <= ins_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      stk_q     <= stk_d;
    end
  end

  assign out_valid  = val_q;
  assign out_instr  = ins_q;
  assign out_err    = err_q;
  assign out_addr   = addr_q;
  assign err_sticky = stk_q;
  assign word_count = cnt_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder: accepts decoded fields (type, registers, funct codes, full 32-bit immediate) over a valid/ready handshake.
- Emits the packed 32-bit instruction word with a sequential word address for writing into instruction memory.
- Used by the debug/boot loader and self-test sequencer to build programs in IMEM.
- Two-stage pipeline (field capture, encode/output register), full throughput, immediate range checking with per-word and sticky error flags.

Parameters:
- ADDR_W, 10, width of word address counter
- BASE_ADDR, 0, word address loaded on reset and on clear

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush: empty pipeline, address to BASE_ADDR, clear err_sticky
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept bundle
- in_op  input  4  0 ALUreg, 1 ALUimm, 2 Load, 3 Store, 4 LUI, 5 AUIPC, 6 JAL, 7 JALR, 8 SYSTEM, 9 Branch; 10-15 illegal
- in_rd, in_rs1, in_rs2  input  5 each  register indices
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (ALUreg, and ALUimm shifts)
- in_imm  input  32  immediate as signed byte offset / full value
- out_valid  output  1  encoded word valid
- out_ready  input  1  downstream accepts word
- out_instr  output  32  encoded instruction
- out_addr  output  ADDR_W  word address for out_instr
- out_err  output  1  word failed a range/legality check
- err_sticky  output  1  set by any emitted out_err, cleared by reset/clear
- word_count  output  ADDR_W+1  words handed off since reset/clear, saturating

Behaviour:
- Reset (resetn=0, async): both stages empty; out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, err_sticky=0, word_count=0; in_ready=0 while resetn=0, 1 on first cycle after release.
- Stage 1 captures fields on in_valid&&in_ready. in_ready = !s1_full || (s1 moves to s2 this cycle).
- s1 moves to s2 when s2 empty or out_valid&&out_ready. Latency: accept at edge N -> out_valid high after edge N+1. Sustained one word/cycle when out_ready=1.
- out_instr, out_addr, out_err stable while out_valid&&!out_ready.
- Handoff (out_valid&&out_ready): address increments, wraps 2^ADDR_W-1 -> 0 (not BASE_ADDR); word_count +1, saturates at all-ones.
- Encoding, standard RV32I opcodes 0110011, 0010011, 0000011, 0100011, 0110111, 0010111, 1101111, 1100111, 1110011, 1100011; rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20].
- R: funct7 [31:25].
- I (ALUimm, Load, JALR, SYSTEM): imm[11:0] -> [31:20]; err if imm outside -2048..2047.
- ALUimm with funct3 001/101: [31:25]=funct7, [24:20]=imm[4:0]; err if imm outside 0..31.
- S: imm[11:5] -> [31:25], imm[4:0] -> [11:7]; range as I.
- B: imm[12|10:5] -> [31|30:25], imm[4:1|11] -> [11:8|7]; err if imm outside -4096..4094 or imm[0]=1.
- U: imm[31:12] -> [31:12]; err if imm[11:0]!=0.
- J: imm[20|10:1|11|19:12] -> [31|30:21|20|19:12]; err if imm outside -1048576..1048574 or imm[0]=1.
- Fields not used by a format are ignored, never cause err.
- Illegal op: out_instr=0, out_err=1. On err, out_instr still carries the truncated encoding.
- err_sticky sets on handoff of a word with out_err=1.
- clear priority: overrides same-cycle input accept and output handoff. Neither counts; pipeline empties, out_valid=0 next cycle; in_ready may be 1 in the clear cycle, but the bundle is dropped.

Test Plan:
- ALUimm rd=1 rs1=0 f3=0 imm=5 -> out_instr=0x00500093, out_addr=0, out_err=0; out_valid after second edge.
- Back-to-back, out_ready=1: ADD rd=3 rs1=1 rs2=2 -> 0x002081B3 @1; Store rs1=1 rs2=2 f3=2 imm=8 -> 0x0020A423 @2; Branch f3=0 imm=-4 -> 0xFE000EE3 @3; JAL rd=1 imm=2048 -> 0x001000EF @4; in_ready stays 1 throughout.
- Errors: Branch imm=3 -> out_err=1, err_sticky=1 after handoff; SLLI (ALUimm f3=1) imm=32 -> out_err=1; LUI imm=0x12345001 -> out_err=1; op=12 -> out_instr=0, out_err=1.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> two bundles held, in_ready=0, outputs stable; release -> both emitted in order, no loss or duplication.
- Wrap/saturate with ADDR_W=2, BASE_ADDR=1: 5 handoffs -> addresses 1,2,3,0,1; word_count=5.
- clear with a word pending and in_valid=1 -> next cycle out_valid=0, out_addr=BASE_ADDR, err_sticky=0, word_count=0. Async resetn pulse mid-stream -> all reset values immediately.
